// File: rtl/fir3_datapath.sv
// Three-tap FIR datapath: sample/delay taps, programmable coefficient bank,
// two-stage multiply/sum pipeline, final-result capture and a result counter.
`timescale 1ns/1ps
module fir3_datapath #(
    parameter int DATAWIDTH = 16,
    parameter int COEFWIDTH = 16,
    parameter int OUTWIDTH  = DATAWIDTH + COEFWIDTH + 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ld_x,
    input  logic                        ld_delay1,
    input  logic                        ld_delay2,
    input  logic                        ld_y,
    input  logic                        done,
    input  logic signed [DATAWIDTH-1:0] x_in,
    input  logic                        coef_we,
    input  logic [1:0]                  coef_addr,
    input  logic signed [COEFWIDTH-1:0] coef_data,
    output logic signed [OUTWIDTH-1:0]  y_out,
    output logic                        y_valid,
    output logic signed [OUTWIDTH-1:0]  y_final,
    output logic                        final_valid,
    output logic                        coef_err,
    output logic [15:0]                 sample_count
);

    localparam int PW = DATAWIDTH + COEFWIDTH;

    // Index 0 is the sample register, 1 and 2 are the delay taps.
    logic signed [DATAWIDTH-1:0] tap_reg  [3];
    logic signed [DATAWIDTH-1:0] tap_src  [3];
    logic signed [COEFWIDTH-1:0] coef_reg [3];
    logic signed [PW-1:0]        prod_reg [3];
    logic signed [OUTWIDTH-1:0]  prod_ext [3];
    logic [2:0]                  tap_ld;
    logic [2:0]                  coef_sel;
    logic                        coef_wr_ok;
    logic                        coef_wr_bad;
    logic                        v0_reg;
    logic                        v1_reg;
    logic signed [OUTWIDTH-1:0]  sum_next;

    assign tap_ld      = {ld_delay2, ld_delay1, ld_x};
    assign coef_wr_ok  = coef_we && !ld_x && (coef_addr != 2'd3);
    assign coef_wr_bad = coef_we && (ld_x || (coef_addr == 2'd3));

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign tap_src[gi] = x_in;
            end else begin : g_body
                assign tap_src[gi] = tap_reg[gi-1];
            end
            assign coef_sel[gi] = coef_wr_ok && (coef_addr == 2'(gi));
            assign prod_ext[gi] = {{(OUTWIDTH-PW){prod_reg[gi][PW-1]}}, prod_reg[gi]};
        end
    endgenerate

    assign sum_next = prod_ext[0] + prod_ext[1] + prod_ext[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                tap_reg[i]  <= '0;
                coef_reg[i] <= '0;
                prod_reg[i] <= '0;
            end
            v0_reg       <= 1'b0;
            v1_reg       <= 1'b0;
            y_valid      <= 1'b0;
            y_out        <= '0;
            y_final      <= '0;
            final_valid  <= 1'b0;
            coef_err     <= 1'b0;
            sample_count <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (tap_ld[i]) begin
                    tap_reg[i] <= tap_src[i];
                end
                if (coef_sel[i]) begin
                    coef_reg[i] <= coef_data;
                end
                prod_reg[i] <= PW'(coef_reg[i]) * PW'(tap_reg[i]);
            end
            v0_reg  <= ld_x;
            v1_reg  <= v0_reg;
            y_valid <= v1_reg;
            y_out   <= sum_next;
            if (ld_y) begin
                y_final <= y_out;
            end
            // Drain condition evaluated on the valid bits this edge produces,
            // so it rises on the edge right after the last y_valid pulse.
            final_valid <= done && !ld_x && !v0_reg && !v1_reg;
            if (coef_wr_bad) begin
                coef_err <= 1'b1;
            end
            if (y_valid && (sample_count != 16'hFFFF)) begin
                sample_count <= sample_count + 16'd1;
            end
        end
    end

endmodule
